// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Samples Width level inputs on a programmable strobe and detects both edges
//   on every channel. Each detected edge sets that channel's pending flag.
//   Pending channels are served round-robin and offered one at a time on a
//   single valid/ready event channel.
//
// Ports
//   clk, sres            clock (rising edge), asynchronous active-high reset
//   enable               lets the sample divider run; arbitration continues when low
//   sample_div           strobe period minus one (0 = strobe every cycle)
//   clear_all            synchronous clear of pending, overflow and the offer FSM
//   Level_In             level inputs, already synchronous to clk
//   evt_ready            consumer accepts the offered event
//   evt_valid/idx/level  offered event: channel and its level after the edge
//   pending              per-channel event awaiting service
//   overflow             sticky: an edge arrived while the channel was already pending
module edge_event_arbiter #(
  parameter int unsigned Width     = 4,
  parameter int unsigned Idx_Width = 2,
  parameter int unsigned Div_Width = 8
) (
  input  logic                 clk,
  input  logic                 sres,
  input  logic                 enable,
  input  logic [Div_Width-1:0] sample_div,
  input  logic                 clear_all,
  input  logic [Width-1:0]     Level_In,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [Idx_Width-1:0] evt_idx,
  output logic                 evt_level,
  output logic [Width-1:0]     pending,
  output logic [Width-1:0]     overflow
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StOffer = 1'b1;

  // Start the first search at channel 0.
  localparam logic [Idx_Width-1:0] LastInit = Idx_Width'(Width - 1);

  logic [Div_Width-1:0] div_cnt_q, div_cnt_d;
  logic [Width-1:0]     level_delay_q, level_delay_d;
  logic                 primed_q, primed_d;
  logic [Width-1:0]     pending_q, pending_d;
  logic [Width-1:0]     overflow_q, overflow_d;
  logic [0:0]           state_q, state_d;
  logic [Idx_Width-1:0] evt_idx_q, evt_idx_d;
  logic                 evt_level_q, evt_level_d;
  logic [Idx_Width-1:0] last_grant_q, last_grant_d;

  logic                 strobe;
  logic [Width-1:0]     edges;
  logic                 handshake;
  logic [Width-1:0]     hs_vec;
  logic [Idx_Width-1:0] sel_idx;
  logic                 sel_found;
  int unsigned          cand;
  logic [Idx_Width-1:0] cand_idx;

  // Sample divider and edge detection
  always_comb begin
    strobe    = enable && (div_cnt_q == sample_div);
    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = strobe ? '0 : div_cnt_q + Div_Width'(1);
    end
    level_delay_d = strobe ? Level_In : level_delay_q;
    primed_d      = primed_q | strobe;
    // The priming strobe only captures a reference level.
    edges = (strobe && primed_q) ? (Level_In ^ level_delay_q) : '0;
  end

  // Pending / overflow bookkeeping
  always_comb begin
    handshake = (state_q == StOffer) && evt_ready;
    hs_vec    = '0;
    if (handshake) begin
      hs_vec[evt_idx_q] = 1'b1;
    end
    // An edge on the channel being handed over re-arms it without overflow.
    pending_d  = clear_all ? '0 : ((pending_q & ~hs_vec) | edges);
    overflow_d = clear_all ? '0 : (overflow_q | (edges & pending_q & ~hs_vec));
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= Width; off++) begin
      cand     = (32'(last_grant_q) + off) % Width;
      cand_idx = Idx_Width'(cand);
      if (!sel_found && pending_q[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Offer FSM
  always_comb begin
    state_d      = state_q;
    evt_idx_d    = evt_idx_q;
    evt_level_d  = evt_level_q;
    last_grant_d = last_grant_q;
    if (clear_all) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      if (sel_found) begin
        state_d     = StOffer;
        evt_idx_d   = sel_idx;
        evt_level_d = level_delay_q[sel_idx];
      end
    end else if (evt_ready) begin
      state_d      = StIdle;
      last_grant_d = evt_idx_q;
    end
  end

  always_ff @(posedge clk or posedge sres) begin
    if (sres) begin
      div_cnt_q     <= '0;
      level_delay_q <= '0;
      primed_q      <= 1'b0;
      pending_q     <= '0;
      overflow_q    <= '0;
      state_q       <= StIdle;
      evt_idx_q     <= '0;
      evt_level_q   <= 1'b0;
      last_grant_q  <= LastInit;
    end else begin
      div_cnt_q     <= div_cnt_d;
      level_delay_q <= level_delay_d;
      primed_q      <= primed_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      evt_idx_q     <= evt_idx_d;
      evt_level_q   <= evt_level_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign evt_valid = (state_q == StOffer);
  assign evt_idx   = evt_idx_q;
  assign evt_level = evt_level_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: vector table for the single-cycle
// handshake sequences, hand-written sequences for divider and async reset.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       sres;
  logic       enable;
  logic [7:0] sample_div;
  logic       clear_all;
  logic [3:0] Level_In;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_idx;
  logic       evt_level;
  logic [3:0] pending;
  logic [3:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;

  edge_event_arbiter #(
    .Width     (4),
    .Idx_Width (2),
    .Div_Width (8)
  ) dut (
    .clk        (clk),
    .sres       (sres),
    .enable     (enable),
    .sample_div (sample_div),
    .clear_all  (clear_all),
    .Level_In   (Level_In),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_level  (evt_level),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lvl;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [1:0] idx;
    logic       el;
    logic [3:0] pend;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs[22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int ev_cnt;
    int first_v;

    //             lvl      rdy   clr    v     idx   el    pend     ovf
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0000};
    vecs[1]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0101, 4'b0000};
    vecs[2]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000};
    vecs[3]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0100, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[5]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000};
    vecs[6]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000};
    vecs[7]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0110, 4'b0000};
    vecs[9]  = '{4'b0111, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0110, 4'b0000};
    vecs[10] = '{4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000};
    vecs[11] = '{4'b0111, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000};
    vecs[12] = '{4'b0111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    // Hold channel 0 in OFFER while channel 3 toggles twice.
    vecs[13] = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000};
    vecs[14] = '{4'b0110, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000};
    vecs[15] = '{4'b1110, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1001, 4'b0000};
    vecs[16] = '{4'b0110, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b1001, 4'b1000};
    vecs[17] = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b1000};
    vecs[18] = '{4'b0110, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'b1000, 4'b1000};
    vecs[19] = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b1000};
    vecs[20] = '{4'b0110, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};
    vecs[21] = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000};

    sres       = 1'b1;
    enable     = 1'b1;
    sample_div = 8'd0;
    clear_all  = 1'b0;
    Level_In   = 4'b0101;
    evt_ready  = 1'b1;
    #12;
    chk("reset_valid", 32'(evt_valid), 32'd0);
    chk("reset_idx", 32'(evt_idx), 32'd0);
    chk("reset_level", 32'(evt_level), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    sres = 1'b0;

    // Static levels: priming strobe must not create events.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("static_valid[%0d]", i), 32'(evt_valid), 32'd0);
      chk($sformatf("static_pend[%0d]", i), 32'(pending | overflow), 32'd0);
    end

    for (int i = 0; i < 22; i++) begin
      Level_In  = vecs[i].lvl;
      evt_ready = vecs[i].rdy;
      clear_all = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].v));
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_idx", i), 32'(evt_idx), 32'(vecs[i].idx));
        chk($sformatf("vec%0d_level", i), 32'(evt_level), 32'(vecs[i].el));
      end
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
    end
    clear_all = 1'b0;

    // Drop bit 1 and let the event drain at sample_div=0.
    Level_In = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_valid", 32'(evt_valid), 32'd0);
    chk("drain_pending", 32'(pending), 32'd0);

    // sample_div=3: strobes on the 4th, 8th, 12th... edge from here.
    sample_div = 8'd3;
    tick();
    Level_In = 4'b0110;
    tick();
    tick();
    Level_In = 4'b0100;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("pulse_valid[%0d]", i), 32'(evt_valid), 32'd0);
      chk($sformatf("pulse_pending[%0d]", i), 32'(pending), 32'd0);
    end
    Level_In = 4'b0110;
    ev_cnt   = 0;
    first_v  = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (evt_valid) begin
        ev_cnt++;
        if (first_v < 0) first_v = i;
        chk("held_idx", 32'(evt_idx), 32'd1);
        chk("held_level", 32'(evt_level), 32'd1);
      end
    end
    chk("held_event_count", 32'(ev_cnt), 32'd1);
    chk("held_first_valid_cycle", 32'(first_v), 32'd5);

    // Async reset in the middle of an OFFER.
    sample_div = 8'd0;
    evt_ready  = 1'b0;
    Level_In   = 4'b0101;
    tick();
    tick();
    chk("offer_valid", 32'(evt_valid), 32'd1);
    chk("offer_idx", 32'(evt_idx), 32'd0);
    chk("offer_level", 32'(evt_level), 32'd1);
    #3;
    sres = 1'b1;
    #1;
    chk("async_valid", 32'(evt_valid), 32'd0);
    chk("async_pending", 32'(pending), 32'd0);
    chk("async_overflow", 32'(overflow), 32'd0);
    #2;
    sres      = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("reprime_valid[%0d]", i), 32'(evt_valid), 32'd0);
      chk($sformatf("reprime_pending[%0d]", i), 32'(pending), 32'd0);
    end
    Level_In = 4'b1101;
    tick();
    chk("alive_pending", 32'(pending), 32'b1000);
    tick();
    chk("alive_valid", 32'(evt_valid), 32'd1);
    chk("alive_idx", 32'(evt_idx), 32'd3);
    chk("alive_level", 32'(evt_level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Sequences both-edge detection across Width level inputs and arbitrates the resulting events onto one valid/ready event channel.
- Generates the sample-load strobe (the ld_en role) from a programmable divider, and holds one pending flag per channel.
- Serves pending channels round-robin, one event per handshake, and flags lost events per channel.
- Sits between raw status/level inputs and a single downstream event consumer (interrupt or logging logic).

Parameters:
Width, 4, number of level inputs/channels (>=2)
Idx_Width, 2, width of evt_idx; must equal ceil(log2(Width))
Div_Width, 8, width of sample_div

Ports:
clk  input  1  system clock, rising edge
sres  input  1  asynchronous active-high reset
enable  input  1  allows sample strobes; arbitration continues when low
sample_div  input  Div_Width  strobe period minus 1; 0 = strobe every cycle
clear_all  input  1  synchronous clear of pending, overflow, FSM
Level_In  input  Width  level inputs, already synchronous to clk
evt_ready  input  1  consumer accepts event
evt_valid  output  1  event offered
evt_idx  output  Idx_Width  channel of offered event
evt_level  output  1  channel level after the edge (1 = rising, 0 = falling)
pending  output  Width  per-channel event awaiting service
overflow  output  Width  sticky: edge arrived while channel already pending

Behaviour:
- Reset (async, immediate): div counter=0, Level_Delay=0, primed=0, pending=0, overflow=0, evt_valid=0, evt_idx=0, evt_level=0, FSM=IDLE, last_grant=Width-1 (first search starts at channel 0).
- Divider: counts only while enable=1. strobe=1 when enable=1 and count==sample_div; count then returns to 0, otherwise increments. enable=0 holds count. A change to sample_div takes effect on the next compare.
- On strobe: Level_Delay<=Level_In. The first strobe after reset sets primed=1 and generates no edges.
- edge[i] = strobe & primed & (Level_In[i]^Level_Delay[i]).
- pending[i] next state, in priority order:
  - clear_all=1: pending[i]=0.
  - edge[i]=1: pending[i]=1.
  - handshake on channel i: pending[i]=0.
  - otherwise: pending[i] holds.
- overflow[i] set when edge[i]=1, pending[i]=1, and no handshake on i in the same cycle. An edge coinciding with a handshake on i re-arms pending with no overflow. overflow clears only via clear_all or reset.
- Channel level: Level_Delay[i] holds the level after the last detected edge.
- FSM IDLE: if pending!=0 and clear_all=0, select the first set bit searching last_grant+1, +2, ... with wrap at Width-1 to 0. Register evt_idx=sel and evt_level=Level_Delay[sel], set evt_valid=1, go to OFFER.
- FSM OFFER: evt_valid, evt_idx and evt_level stay stable until evt_ready=1. On handshake (evt_valid & evt_ready): clear pending[evt_idx], set last_grant=evt_idx, evt_valid<=0, go to IDLE.
- Throughput: at most one event per 2 cycles.
- Latency: edge sampled at clock k → pending visible after k → evt_valid high after clock k+1. Minimum 2 cycles from the Level_In change to evt_valid at sample_div=0.
- evt_level reflects Level_Delay when the event is loaded. If the channel toggles again before the event is loaded, overflow flags the merge.
- clear_all=1: FSM<=IDLE, evt_valid<=0, pending and overflow cleared. clear_all has priority over a same-cycle edge or handshake. primed, counter, Level_Delay and last_grant are unaffected.
- Pulses shorter than one strobe period that return to the prior level before the next strobe are not detected.

Test Plan:
- Reset, Level_In=4'b0101 held, enable=1, sample_div=0 → no evt_valid for 20 cycles; pending=0; overflow=0.
- Primed, evt_ready=1, Level_In 4'b0000→4'b0001 → evt_valid=1 exactly 2 cycles after change, evt_idx=0, evt_level=1, held 1 cycle; pending[0]=0 afterward.
- Bits 0 and 2 toggle same strobe, evt_ready=1 → events idx 0 then idx 2, two cycles apart. Then bits 1 and 2 toggle → idx 1 then idx 2. overflow stays 0.
- evt_ready=0, bit 3 toggles on two successive strobes → overflow[3]=1, pending[3]=1. evt_ready=1 → one event idx 3 with evt_level=Level_In[3] final value; clear_all → overflow=0.
- sample_div=3 → strobe every 4 cycles. A 2-cycle high pulse on bit 1 between strobes → no event. A level held 5 cycles → exactly one event.
- Async: sres asserted mid-OFFER between clock edges → evt_valid=0 and pending=0 immediately. After release, first strobe primes, so no spurious event.
